// File: rtl/spi_fram_pkg.sv
// Shared definitions for the SPI FRAM responder and its initiator:
// opcode values and the responder frame state encoding.
package spi_fram_pkg;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;

    typedef enum logic [2:0] {
        StIdle,
        StOpcode,
        StAddrHi,
        StAddrLo,
        StWriteData,
        StReadData,
        StIgnore
    } state_e;

endpackage

// File: rtl/spi_fram_slave_if.sv
// Pin-level SPI link plus host backdoor and commit/event outputs of the FRAM responder.
interface spi_fram_slave_if #(
    parameter int unsigned ADDR_W = 6
);

    logic              spi_clk;
    logic              spi_cs;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic [ADDR_W-1:0] host_addr;
    logic              host_wr_en;
    logic [7:0]        host_wr_data;
    logic [7:0]        host_rd_data;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_byte;
    logic              host_collision;
    logic              frame_done;

    modport slave (
        input  spi_clk, spi_cs, spi_mosi, host_addr, host_wr_en, host_wr_data,
        output spi_miso, spi_miso_oe, host_rd_data, wr_strobe, wr_addr, wr_byte,
        output host_collision, frame_done
    );

    modport master (
        output spi_clk, spi_cs, spi_mosi, host_addr, host_wr_en, host_wr_data,
        input  spi_miso, spi_miso_oe, host_rd_data, wr_strobe, wr_addr, wr_byte,
        input  host_collision, frame_done
    );

endinterface

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for an asynchronous SPI pin, followed by one
// history flop that yields single-cycle rise/fall events.
module spi_in_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stages;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= {SYNC_STAGES{RESET_VAL}};
            prev   <= RESET_VAL;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], din};
            prev   <= stages[SYNC_STAGES-1];
        end
    end

    assign level = stages[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_fram_slave.sv
// SPI mode-0 FRAM emulation: READ/WRITE frames against a small register-array
// memory, with a host backdoor that loses to SPI commits in the same cycle.
module spi_fram_slave
    import spi_fram_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 6
) (
    input logic              clk,
    input logic              rst,
    spi_fram_slave_if.slave  bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [7:0] mem [DEPTH];

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic mosi_s;
    logic unused_sclk_level;

    state_e            state;
    logic [2:0]        bit_cnt;
    logic [7:0]        rx_shift;
    logic [7:0]        tx_shift;
    logic [7:0]        opcode;
    logic [ADDR_W-1:0] addr;
    logic              load_pend;
    logic              miso, miso_oe;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_byte;
    logic              frame_done;
    logic              host_collision;
    logic [7:0]        host_rd_data;

    logic [7:0]        rx_next;
    logic              byte_done;
    logic              spi_commit;

    spi_in_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sclk_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.spi_clk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // CS idles high, so its synchronizer resets to 1 to avoid a false frame start.
    spi_in_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.spi_cs),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    assign unused_sclk_level = sclk_level;

    // Same depth as the sclk path so MOSI lines up with the sampled rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_sync <= '0;
        end else begin
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
        end
    end

    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    always_comb begin
        rx_next    = {rx_shift[6:0], mosi_s};
        byte_done  = sclk_rise && (bit_cnt == 3'd7);
        spi_commit = !rst && !cs_level && (state == StWriteData) && byte_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            bit_cnt    <= 3'd0;
            rx_shift   <= 8'h00;
            tx_shift   <= 8'h00;
            opcode     <= 8'h00;
            addr       <= '0;
            load_pend  <= 1'b0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            wr_byte    <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            wr_strobe  <= 1'b0;
            frame_done <= cs_rise;
            if (cs_level) begin
                state     <= StIdle;
                bit_cnt   <= 3'd0;
                rx_shift  <= 8'h00;
                tx_shift  <= 8'h00;
                load_pend <= 1'b0;
                miso      <= 1'b0;
                miso_oe   <= 1'b0;
            end else if (state == StIdle) begin
                if (cs_fall) begin
                    state <= StOpcode;
                end
            end else begin
                if (sclk_rise) begin
                    rx_shift <= rx_next;
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    case (state)
                        StOpcode: begin
                            opcode <= rx_next;
                            if (rx_next == OP_WRITE || rx_next == OP_READ) begin
                                state <= StAddrHi;
                            end else begin
                                state <= StIgnore;
                            end
                        end
                        StAddrHi: state <= StAddrLo;
                        StAddrLo: begin
                            addr <= rx_next[ADDR_W-1:0];
                            if (opcode == OP_READ) begin
                                state     <= StReadData;
                                tx_shift  <= mem[rx_next[ADDR_W-1:0]];
                                miso      <= mem[rx_next[ADDR_W-1:0]][7];
                                miso_oe   <= 1'b1;
                                load_pend <= 1'b1;
                            end else begin
                                state <= StWriteData;
                            end
                        end
                        StWriteData: begin
                            wr_strobe <= 1'b1;
                            wr_addr   <= addr;
                            wr_byte   <= rx_next;
                            addr      <= addr + ADDR_W'(1);
                        end
                        StReadData: begin
                            addr      <= addr + ADDR_W'(1);
                            load_pend <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                // The first fall after a byte boundary presents the next byte's MSB
                // instead of shifting, so bit 7 is not lost.
                if (state == StReadData && sclk_fall) begin
                    if (load_pend) begin
                        tx_shift  <= mem[addr];
                        miso      <= mem[addr][7];
                        load_pend <= 1'b0;
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        miso     <= tx_shift[6];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (spi_commit) begin
            mem[addr] <= rx_next;
        end else if (bus.host_wr_en) begin
            mem[bus.host_addr] <= bus.host_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            host_rd_data   <= 8'h00;
            host_collision <= 1'b0;
        end else begin
            host_rd_data   <= mem[bus.host_addr];
            host_collision <= bus.host_wr_en && spi_commit;
        end
    end

    assign bus.spi_miso       = miso;
    assign bus.spi_miso_oe    = miso_oe;
    assign bus.wr_strobe      = wr_strobe;
    assign bus.wr_addr        = wr_addr;
    assign bus.wr_byte        = wr_byte;
    assign bus.frame_done     = frame_done;
    assign bus.host_collision = host_collision;
    assign bus.host_rd_data   = host_rd_data;

endmodule

// File: tb/tb_spi_fram_slave.sv
// Scoreboard bench: frames are modelled against a byte array as they are issued;
// monitors compare read bytes, commits and event pulses as the DUT produces them.
module tb_spi_fram_slave;
    import spi_fram_pkg::*;

    localparam int unsigned S     = 2;
    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned H     = S + 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_fram_slave_if #(.ADDR_W(AW)) bus ();

    spi_fram_slave #(
        .SYNC_STAGES (S),
        .ADDR_W      (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0]  ref_mem [DEPTH];
    logic [7:0]  exp_rd_q [$];
    logic [13:0] exp_wr_q [$];
    logic [7:0]  frame_q [$];
    int frame_cnt = 0, exp_frames = 0;
    int coll_cnt = 0, exp_coll = 0;
    int oe_cycles = 0;
    logic [7:0]  rd_acc;
    int rd_bits = 0;
    logic [13:0] wr_e;
    logic [7:0]  rd_e;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Commit/event monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frame_done) frame_cnt++;
            if (bus.host_collision) coll_cnt++;
            if (bus.spi_miso_oe) oe_cycles++;
            if (bus.wr_strobe) begin
                if (exp_wr_q.size() == 0) begin
                    check("wr_unexpected_qsize", exp_wr_q.size(), 1);
                end else begin
                    wr_e = exp_wr_q.pop_front();
                    check("wr_addr", int'(bus.wr_addr), int'(wr_e[13:8]));
                    check("wr_byte", int'(bus.wr_byte), int'(wr_e[7:0]));
                end
            end
        end
    end

    // Read-data monitor: the initiator's view, sampling MISO at SPI rising edges.
    always @(posedge bus.spi_clk) begin
        if (bus.spi_miso_oe) begin
            rd_acc = {rd_acc[6:0], bus.spi_miso};
            rd_bits++;
            if (rd_bits == 8) begin
                rd_bits = 0;
                if (exp_rd_q.size() == 0) begin
                    check("rd_unexpected_qsize", exp_rd_q.size(), 1);
                end else begin
                    rd_e = exp_rd_q.pop_front();
                    check("rd_byte", int'(rd_acc), int'(rd_e));
                end
            end
        end
    end

    always @(posedge bus.spi_cs) rd_bits = 0;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
        bus.host_addr    = a;
        bus.host_wr_data = d;
        bus.host_wr_en   = 1'b1;
        @(negedge clk);
        bus.host_wr_en   = 1'b0;
        ref_mem[a]       = d;
    endtask

    task automatic host_check(input logic [AW-1:0] a);
        bus.host_addr = a;
        wait_clk(2);
        check("host_rd", int'(bus.host_rd_data), int'(ref_mem[a]));
    endtask

    // Expected effects of frame_q: sequential addressing from the third byte,
    // wrapping at the memory size; a trailing partial byte has no effect.
    task automatic model_frame(input int last_bits);
        logic [AW-1:0] a;
        int full;
        exp_frames++;
        full = frame_q.size() - ((last_bits < 8) ? 1 : 0);
        a = frame_q[2][AW-1:0];
        for (int i = 3; i < full; i++) begin
            if (frame_q[0] == OP_WRITE) begin
                ref_mem[a] = frame_q[i];
                exp_wr_q.push_back({a, frame_q[i]});
            end else if (frame_q[0] == OP_READ) begin
                exp_rd_q.push_back(ref_mem[a]);
            end
            a = (a + 1) % DEPTH;
        end
    endtask

    task automatic spi_frame(input int last_bits, input int coll_byte,
                             input logic [AW-1:0] h_addr, input logic [7:0] h_data,
                             input bit hold_cs);
        bus.spi_cs = 1'b0;
        for (int i = 0; i < frame_q.size(); i++) begin
            int nb;
            nb = (i == frame_q.size() - 1) ? last_bits : 8;
            for (int b = 7; b > 7 - nb; b--) begin
                bus.spi_mosi = frame_q[i][b];
                wait_clk(H);
                bus.spi_clk = 1'b1;
                for (int k = 1; k <= H; k++) begin
                    @(negedge clk);
                    // Host write aligned to the clk in which the SPI commit lands.
                    if (i == coll_byte && b == 0) begin
                        if (k == S) begin
                            bus.host_addr    = h_addr;
                            bus.host_wr_data = h_data;
                            bus.host_wr_en   = 1'b1;
                        end else if (k == S + 1) begin
                            bus.host_wr_en = 1'b0;
                        end
                    end
                end
                bus.spi_clk = 1'b0;
            end
        end
        wait_clk(H);
        if (!hold_cs) begin
            bus.spi_cs   = 1'b1;
            bus.spi_mosi = 1'b0;
            wait_clk(H + 4);
        end
    endtask

    task automatic run_frame(input int last_bits);
        model_frame(last_bits);
        spi_frame(last_bits, -1, '0, 8'h00, 1'b0);
        check("rd_pending", exp_rd_q.size(), 0);
        check("wr_pending", exp_wr_q.size(), 0);
        check("frame_done_cnt", frame_cnt, exp_frames);
    endtask

    task automatic check_reset_outputs();
        check("rst_miso", int'(bus.spi_miso), 0);
        check("rst_miso_oe", int'(bus.spi_miso_oe), 0);
        check("rst_wr_strobe", int'(bus.wr_strobe), 0);
        check("rst_wr_addr", int'(bus.wr_addr), 0);
        check("rst_wr_byte", int'(bus.wr_byte), 0);
        check("rst_collision", int'(bus.host_collision), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        check("rst_host_rd", int'(bus.host_rd_data), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int oe0;
        int kind, n, lb;
        logic [7:0] op;
        logic [AW-1:0] a;

        rst = 1'b1;
        bus.spi_clk = 1'b0;
        bus.spi_cs = 1'b1;
        bus.spi_mosi = 1'b0;
        bus.host_addr = '0;
        bus.host_wr_en = 1'b0;
        bus.host_wr_data = 8'h00;
        wait_clk(4);
        check_reset_outputs();
        rst = 1'b0;
        wait_clk(2);

        for (int i = 0; i < DEPTH; i++) host_write(AW'(i), 8'($urandom));
        host_write(6'd5, 8'hA5);

        frame_q = '{8'h03, 8'h00, 8'h05, 8'h00};
        run_frame(8);

        frame_q = '{8'h02, 8'h00, 8'h3F, 8'h11, 8'h22};
        run_frame(8);
        host_check(6'd63);
        host_check(6'd0);

        host_write(6'd62, 8'h01);
        host_write(6'd63, 8'h02);
        host_write(6'd0, 8'h03);
        frame_q = '{8'h03, 8'h00, 8'h3E, 8'h00, 8'h00, 8'h00};
        run_frame(8);

        frame_q = '{8'h02, 8'h00, 8'h10, 8'hAB};
        run_frame(5);
        host_check(6'd16);
        frame_q = '{8'h03, 8'h00, 8'h10, 8'h00};
        run_frame(8);

        oe0 = oe_cycles;
        frame_q = '{8'h9F, 8'($urandom), 8'($urandom), 8'($urandom)};
        run_frame(8);
        check("ignore_oe_cycles", oe_cycles - oe0, 0);
        frame_q = '{8'h03, 8'h00, 8'h05, 8'h00};
        run_frame(8);

        // Host write to a neighbouring address in the commit cycle is dropped.
        frame_q = '{8'h02, 8'h00, 8'h20, 8'h5A};
        model_frame(8);
        exp_coll++;
        spi_frame(8, 3, 6'd33, 8'hC3, 1'b0);
        check("wr_pending", exp_wr_q.size(), 0);
        check("collision_cnt", coll_cnt, exp_coll);
        host_check(6'd32);
        host_check(6'd33);

        for (int f = 0; f < 20; f++) begin
            kind = $urandom_range(0, 2);
            n = $urandom_range(1, 4);
            a = AW'($urandom);
            if (kind == 0) op = OP_WRITE;
            else if (kind == 1) op = OP_READ;
            else begin
                op = 8'($urandom);
                while (op == OP_WRITE || op == OP_READ) op = 8'($urandom);
            end
            frame_q = '{op, 8'h00, {2'b00, a}};
            for (int j = 0; j < n; j++) frame_q.push_back(8'($urandom));
            lb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            run_frame(lb);
        end
        for (int j = 0; j < 8; j++) host_check(AW'($urandom));
        check("collision_cnt_final", coll_cnt, exp_coll);

        // Reset in the middle of a READ data byte.
        frame_q = '{8'h03, 8'h00, 8'h05, 8'h00};
        spi_frame(3, -1, '0, 8'h00, 1'b1);
        check("oe_in_read", int'(bus.spi_miso_oe), 1);
        bus.host_addr = 6'd5;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        bus.spi_cs = 1'b1;
        wait_clk(H + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_fram_slave.md
# spi_fram_slave

SPI mode-0 responder that emulates the subset of an FM25L16-style FRAM used by our memory controller. It holds a 64-byte register-array memory. It decodes READ (0x03) and WRITE (0x02) frames from an SPI initiator and drives read data back MSB first. It sits on the far end of the SPI link as the FPGA-side memory target, and doubles as the bench model for the initiator. A host-side backdoor port allows preload and inspection.

## Interface
- SYNC_STAGES, 2, synchronizer depth on spi_clk/spi_cs/spi_mosi (≥2)
- ADDR_W, 6, memory address width; depth = 2**ADDR_W
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- spi_clk  in  1  SPI clock from initiator, idle low
- spi_cs  in  1  chip select, active low
- spi_mosi  in  1  initiator data out
- spi_miso  out  1  responder data out, MSB first
- spi_miso_oe  out  1  high while a READ data phase is active
- host_addr  in  ADDR_W  backdoor address
- host_wr_en  in  1  backdoor write strobe
- host_wr_data  in  8  backdoor write data
- host_rd_data  out  8  mem[host_addr], registered, 1-cycle latency
- wr_strobe  out  1  one-cycle pulse per SPI-committed byte
- wr_addr  out  ADDR_W  address of last SPI commit
- wr_byte  out  8  data of last SPI commit
- host_collision  out  1  one-cycle pulse: host write dropped
- frame_done  out  1  one-cycle pulse when CS rises after any frame

## Operation
- Inputs pass through SYNC_STAGES flops, then one more flop for edge detection: sclk_rise, sclk_fall, cs_fall, cs_rise.
- States: IDLE, OPCODE, ADDR_HI, ADDR_LO, WRITE_DATA, READ_DATA, IGNORE.
- A synchronized cs high forces IDLE from any state, clears the bit counter and shift registers, and drops spi_miso_oe. This applies at any clk, including mid-byte.
- IDLE→OPCODE on cs_fall.
- Sampling: spi_mosi is shifted into rx_shift on each sclk_rise. A 3-bit counter is incremented, and the byte completes when it wraps 7→0.
- OPCODE transitions on byte completion: 0x02 or 0x03 → ADDR_HI, with the opcode latched; any other value → IGNORE.
- ADDR_HI ignores its byte. The initiator sends 0x00.
- ADDR_LO latches rx_shift[ADDR_W-1:0] into addr, then transitions:
  - WRITE → WRITE_DATA.
  - READ → READ_DATA, with tx_shift loaded from mem[addr].
- WRITE_DATA, on each completed byte:
  - write mem[addr];
  - pulse wr_strobe with wr_addr/wr_byte;
  - addr += 1 modulo 2**ADDR_W (63→0 wraps).
- READ_DATA:
  - spi_miso = tx_shift[7]; tx_shift shifts left on each sclk_fall.
  - On byte completion: addr += 1 (wrap), and tx_shift reloads from mem[addr+1] at the following sclk_fall.
- IGNORE: consume bits until cs high. No memory effect, spi_miso_oe low.
- Partial bytes at cs rise are discarded. A partial WRITE byte is never committed.
- Host port:
  - host_rd_data is always valid.
  - host_wr_en writes mem[host_addr] unless an SPI commit occurs in the same clk. In that case the SPI commit wins and host_collision pulses.

## Timing
- Edge-detect latency: SYNC_STAGES+1 clk from a pin transition to its internal event.
- Constraint on the initiator: spi_clk high and low phases each ≥ SYNC_STAGES+3 clk. cs setup before the first rising spi_clk edge is subject to the same bound.
- First READ data bit:
  - Driven in the clk after the last sclk_fall of the ADDR_LO byte.
  - If that fall precedes ADDR_LO completion, the bit is driven 1 clk after ADDR_LO completes.
  - Either way it is valid before the first data rising edge.
- spi_miso changes only 1 clk after sclk_fall, or on entry to READ_DATA. It is stable across rising edges.
- SPI memory write occurs 1 clk after the 8th sclk_rise of a data byte. wr_strobe is asserted in that same cycle.
- frame_done asserts 1 clk after cs_rise.
- Reset values: spi_miso=0, spi_miso_oe=0, wr_strobe=0, wr_addr=0, wr_byte=0, host_collision=0, frame_done=0, host_rd_data=0, state IDLE, addr=0. Memory contents are not reset.

## Structure
- Shared package spi_fram_pkg: opcode constants OP_WRITE=8'h02 and OP_READ=8'h03, plus the state enum. The initiator imports the same opcodes.
- One sub-module, spi_in_sync: a SYNC_STAGES synchronizer plus edge detector, instantiated for spi_clk and spi_cs. spi_mosi uses the synchronizer only.

## Test plan
- Host preloads mem[5]=0xA5. SPI frame 03 00 05 00 → initiator receives 0xA5, spi_miso_oe high only during byte 3, frame_done once.
- SPI frame 02 00 3F 11 22 → mem[63]=0x11, mem[0]=0x22 (wrap), two wr_strobe pulses, wr_addr 63 then 0.
- Burst READ 03 00 3E + 3 dummy bytes after preloading 0x01/0x02/0x03 at 62/63/0 → bytes 01 02 03.
- cs deasserted after 5 bits of the WRITE data byte → no memory change, no wr_strobe, next READ frame works normally.
- Opcode 0x9F followed by 3 bytes → no writes, spi_miso_oe stays 0, FSM back in IDLE after cs rise.
- host_wr_en in the same clk as an SPI commit to any address → the SPI data is kept, host_collision pulses once. rst asserted mid-frame → outputs return to reset values on the next clk.
